// File: rtl/hello_scroll_pkg.sv
// Shared definitions for the hello-message scroll controller: rotation
// geometry and the FSM state encoding shown on the LEDs.
package hello_scroll_pkg;

  localparam int unsigned NPOS  = 5;
  localparam int unsigned SEL_W = 3;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_RUN   = 2'd1;
  localparam logic [1:0] STATE_HOLD  = 2'd2;
  localparam logic [1:0] STATE_DWELL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_RUN   = STATE_RUN,
    ST_HOLD  = STATE_HOLD,
    ST_DWELL = STATE_DWELL
  } state_e;

endpackage

// File: rtl/scroll_prescaler.sv
// Scroll-step prescaler: counts 0..TICK_DIV-1 while enabled and pulses
// tc_o in the cycle holding the terminal count. clr_i wins over en_i.
module scroll_prescaler #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == LAST);

  // Next count: clear, wrap at terminal count, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Scroll controller for the rotating HELLO display: auto-advances the
// 5-position rotation select every TICK_DIV cycles, or once per STEP key
// press while idle/held. Optional home-position dwell is enabled with the
// HELLO_SCROLL_DWELL_EN macro.
module hello_scroll_ctrl
  import hello_scroll_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned DWELL_TICKS = 3
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             RUN_EN,
  input  logic             DIR,
  input  logic             STEP,
  input  logic             HOME,
  output logic [SEL_W-1:0] SEL,
  output logic             ADV,
  output logic             WRAP,
  output logic [1:0]       STATE
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             adv_q, adv_d;
  logic             wrap_q, wrap_d;
  logic             step_q, step_arm_q;
  logic             step_rise;
  logic             active, tick, advance;
  logic [SEL_W-1:0] sel_nxt;
  logic             wrap_nxt;

`ifdef HELLO_SCROLL_DWELL_EN
  localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          dwell_done;
  assign dwell_done = (32'(dwell_q) + 32'd1 >= DWELL_TICKS);
`else
  // DWELL_TICKS has no effect in this build.
  logic unused_dwell;
  assign unused_dwell = (DWELL_TICKS != 0);
`endif

  // step_arm_q blocks an edge for a key already held through reset release.
  assign step_rise = STEP && !step_q && step_arm_q;
  assign active    = (state_q == ST_RUN) || (state_q == ST_DWELL);

  scroll_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk_i(CLOCK_50),
    .rst_i(RESET),
    .clr_i(HOME || !RUN_EN || !active),
    .en_i (active),
    .tc_o (tick)
  );

  assign sel_nxt  = DIR ? ((sel_q == '0) ? SEL_W'(NPOS - 1) : sel_q - SEL_W'(1))
                        : ((sel_q == SEL_W'(NPOS - 1)) ? '0 : sel_q + SEL_W'(1));
  assign wrap_nxt = DIR ? (sel_q == '0) : (sel_q == SEL_W'(NPOS - 1));

  // Next state, rotation index and pulses; HOME beats RUN_EN beats advance.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    adv_d   = 1'b0;
    wrap_d  = 1'b0;
    advance = 1'b0;
`ifdef HELLO_SCROLL_DWELL_EN
    dwell_d = dwell_q;
`endif
    if (HOME) begin
      sel_d   = '0;
      state_d = RUN_EN ? ST_RUN : ST_IDLE;
`ifdef HELLO_SCROLL_DWELL_EN
      dwell_d = '0;
      if (RUN_EN && state_q == ST_DWELL)
        state_d = ST_DWELL;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (RUN_EN)
            state_d = ST_RUN;
          else if (step_rise)
            advance = 1'b1;
        end
        ST_RUN: begin
          if (!RUN_EN)
            state_d = ST_HOLD;
          else if (tick) begin
            advance = 1'b1;
`ifdef HELLO_SCROLL_DWELL_EN
            if (sel_nxt == '0) begin
              state_d = ST_DWELL;
              dwell_d = '0;
            end
`endif
          end
        end
`ifdef HELLO_SCROLL_DWELL_EN
        ST_DWELL: begin
          if (!RUN_EN) begin
            state_d = ST_HOLD;
            dwell_d = '0;
          end else if (tick) begin
            if (dwell_done) begin
              state_d = ST_RUN;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
    if (advance) begin
      sel_d  = sel_nxt;
      adv_d  = 1'b1;
      wrap_d = wrap_nxt;
    end
  end

  // State, select, pulse and STEP edge-detect registers.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      adv_q      <= 1'b0;
      wrap_q     <= 1'b0;
      step_q     <= 1'b0;
      step_arm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      adv_q      <= adv_d;
      wrap_q     <= wrap_d;
      step_q     <= STEP;
      step_arm_q <= step_arm_q | ~STEP;
    end
  end

`ifdef HELLO_SCROLL_DWELL_EN
  // Dwell period counter.
  always_ff @(posedge CLOCK_50) begin
    if (RESET)
      dwell_q <= '0;
    else
      dwell_q <= dwell_d;
  end
`endif

  assign SEL   = sel_q;
  assign ADV   = adv_q;
  assign WRAP  = wrap_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Self-checking bench for hello_scroll_ctrl with TICK_DIV=4, DWELL_TICKS=2.
// Expected advances are queued with their edge number; a monitor pops and
// compares on every ADV pulse.
module tb_hello_scroll_ctrl;

  localparam int unsigned TDIV = 4;
`ifdef HELLO_SCROLL_DWELL_EN
  localparam int DWELL_ON = 1;
`else
  localparam int DWELL_ON = 0;
`endif
  localparam int DEXTRA = DWELL_ON * 2 * TDIV;

  logic       CLOCK_50 = 1'b0;
  logic       RESET, RUN_EN, DIR, STEP, HOME;
  logic [2:0] SEL;
  logic       ADV, WRAP;
  logic [1:0] STATE;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {int cyc; int sel; int wrap;} exp_t;
  exp_t sb[$];

  hello_scroll_ctrl #(
    .TICK_DIV   (TDIV),
    .DWELL_TICKS(2)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .RUN_EN  (RUN_EN),
    .DIR     (DIR),
    .STEP    (STEP),
    .HOME    (HOME),
    .SEL     (SEL),
    .ADV     (ADV),
    .WRAP    (WRAP),
    .STATE   (STATE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int s, input int w);
    exp_t e;
    e.cyc = c; e.sel = s; e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge CLOCK_50);
  endtask

  // Scoreboard monitor: every ADV must match the oldest queued expectation.
  always @(posedge CLOCK_50) begin
    #1;
    if (ADV) begin
      if (sb.size() == 0) begin
        chk("unexpected_adv", int'(ADV), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("adv_edge", cyc, e.cyc);
        chk("adv_sel", int'(SEL), e.sel);
        chk("adv_wrap", int'(WRAP), e.wrap);
      end
    end else if (WRAP) begin
      chk("wrap_without_adv", int'(WRAP), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {int dir; int sel; int wrap; int hold;} step_t;
  step_t steps[4] = '{'{1, 4, 1, 10}, '{1, 3, 0, 1}, '{0, 4, 0, 1}, '{0, 0, 1, 1}};

  initial begin
    int start;
    RESET = 1; RUN_EN = 0; DIR = 0; STEP = 0; HOME = 0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_sel", int'(SEL), 0);
    chk("rst_adv", int'(ADV), 0);
    chk("rst_wrap", int'(WRAP), 0);
    chk("rst_state", int'(STATE), 0);
    RESET = 0;
    @(negedge CLOCK_50);
    chk("idle_state", int'(STATE), 0);

    // Forward auto-scroll from reset.
    start = cyc + 1;
    RUN_EN = 1;
    for (int k = 1; k <= 5; k++) push(start + 4 * k, k % 5, (k == 5) ? 1 : 0);
    wait_to(start + 2);
    chk("run_state", int'(STATE), 1);
    wait_to(start + 20);
    chk("fwd_sel_end", int'(SEL), 0);
    chk("fwd_state_end", int'(STATE), DWELL_ON ? 3 : 1);
    RUN_EN = 0;
    wait_to(start + 22);
    chk("hold_state", int'(STATE), 2);

    // Drop RUN_EN at prescaler count 2 with SEL=2, then resume.
    start = cyc + 1;
    RUN_EN = 1;
    push(start + 4, 1, 0);
    push(start + 8, 2, 0);
    wait_to(start + 10);
    RUN_EN = 0;
    wait_to(start + 22);
    chk("hold_sel", int'(SEL), 2);
    chk("hold_state2", int'(STATE), 2);
    start = cyc + 1;
    RUN_EN = 1;
    push(start + 4, 3, 0);

    // HOME coincident with the terminal-count tick at SEL=3.
    wait_to(start + 7);
    HOME = 1;
    @(negedge CLOCK_50);
    HOME = 0;
    chk("home_sel", int'(SEL), 0);
    chk("home_adv", int'(ADV), 0);
    chk("home_state", int'(STATE), 1);
    push(start + 12, 1, 0);
    wait_to(start + 13);
    chk("after_home_sel", int'(SEL), 1);

    // RESET together with HOME.
    RESET = 1; HOME = 1;
    @(negedge CLOCK_50);
    chk("rsthome_sel", int'(SEL), 0);
    chk("rsthome_state", int'(STATE), 0);
    chk("rsthome_adv", int'(ADV), 0);
    RESET = 0; HOME = 0; RUN_EN = 0;
    repeat (6) @(negedge CLOCK_50);
    chk("post_rst_state", int'(STATE), 0);
    chk("post_rst_sel", int'(SEL), 0);

    // Manual STEP advances in IDLE, including a long hold and DIR changes.
    foreach (steps[i]) begin
      DIR = steps[i].dir[0];
      @(negedge CLOCK_50);
      STEP = 1;
      push(cyc + 1, steps[i].sel, steps[i].wrap);
      repeat (steps[i].hold) @(negedge CLOCK_50);
      STEP = 0;
      @(negedge CLOCK_50);
    end
    chk("step_sel_end", int'(SEL), 0);

    // STEP held high through reset release must not advance.
    STEP = 1; RESET = 1;
    @(negedge CLOCK_50);
    RESET = 0;
    repeat (5) @(negedge CLOCK_50);
    chk("step_thru_rst_sel", int'(SEL), 0);
    STEP = 0;
    @(negedge CLOCK_50);
    STEP = 1;
    push(cyc + 1, 1, 0);
    @(negedge CLOCK_50);
    STEP = 0;
    @(negedge CLOCK_50);
    chk("step_after_rst_sel", int'(SEL), 1);

    // Reverse auto-scroll; STEP toggles in RUN are ignored.
    DIR = 1;
    start = cyc + 1;
    RUN_EN = 1;
    push(start + 4, 0, 0);
    push(start + 8 + DEXTRA, 4, 1);
    push(start + 12 + DEXTRA, 3, 0);
    repeat (3) begin
      @(negedge CLOCK_50); STEP = 1;
      @(negedge CLOCK_50); STEP = 0;
    end
    wait_to(start + 13 + DEXTRA);
    RUN_EN = 0;
    repeat (2) @(negedge CLOCK_50);
    chk("rev_sel", int'(SEL), 3);
    chk("rev_state", int'(STATE), 2);

`ifdef HELLO_SCROLL_DWELL_EN
    // Home-position dwell: two prescaler periods at SEL=0, then resume.
    RESET = 1; DIR = 0;
    @(negedge CLOCK_50);
    RESET = 0;
    start = cyc + 1;
    RUN_EN = 1;
    for (int k = 1; k <= 5; k++) push(start + 4 * k, k % 5, (k == 5) ? 1 : 0);
    push(start + 32, 1, 0);
    wait_to(start + 22);
    chk("dwell_state", int'(STATE), 3);
    wait_to(start + 27);
    chk("dwell_sel", int'(SEL), 0);
    wait_to(start + 29);
    chk("dwell_exit_state", int'(STATE), 1);
    wait_to(start + 33);
    chk("dwell_resume_sel", int'(SEL), 1);
    RUN_EN = 0;
`endif

    repeat (3) @(negedge CLOCK_50);
    chk("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
